dti_gnpd_pkt_buf: RTL
=====================

Name: dti_gnpd_pkt_buf

Overview:
Store-and-forward packet buffer on the DTI-to-NoC request path. It sits directly downstream of the DTI/GNPD converter's custom-side request output (valid/ready/payload/srcid/tgtid/qos/last) and feeds the NoC injection port. A packet is released only once its last beat is stored, so the NoC never sees a stalled partial packet. The block also generates the upstream threshold (space-available) indication and honours the downstream threshold before starting each packet.

Parameters:
DEPTH, 16, number of beat entries; power of two, >= 2; must be >= MAX_PKT.
MAX_PKT, 8, largest legal packet length in beats.
PAYLOAD_W, 90, payload width ({tdata[79:0], tkeep[9:0]}).
ID_W, 6, srcid/tgtid width.
THRESH, 8, minimum free entries for in_threshold = 1; range 1..DEPTH.

Ports:
clk  in  1  clock.
rst  in  1  asynchronous active-high reset.
in_valid  in  1  upstream beat valid.
in_ready  out  1  upstream beat accepted when in_valid && in_ready.
in_payload  in  PAYLOAD_W  beat payload.
in_srcid  in  ID_W  source id.
in_tgtid  in  ID_W  target id.
in_qos  in  1  qos bit.
in_last  in  1  last beat of packet.
in_threshold  out  1  registered; 1 when free entries >= THRESH.
out_valid  out  1  NoC beat valid.
out_ready  in  1  NoC ready.
out_payload  out  PAYLOAD_W  head-entry payload.
out_srcid  out  ID_W  head-entry srcid.
out_tgtid  out  ID_W  head-entry tgtid.
out_qos  out  1  head-entry qos.
out_last  out  1  head-entry last.
out_threshold  in  1  NoC space indication; gates packet start.
err_oversize  out  1  sticky; set on cut-through fallback.

Behaviour:
- Entry = {last, qos, tgtid, srcid, payload}. Read/write pointers are log2(DEPTH)+1 bits, with the MSB used for wrap. Full when the pointers differ only in MSB; empty when equal. Write is registered; out_* come combinationally from the head entry.
- in_ready = !full. A push occurs on in_valid && in_ready.
- pkt_cnt (0..DEPTH): +1 on a push with in_last, -1 on a pop with out_last. A simultaneous push-last and pop-last leaves it unchanged.
- Output FSM:
  - IDLE: out_valid = 0. Move to BURST when !empty && (pkt_cnt != 0 || cut_mode) && out_threshold. Evaluation is registered, so the first out_valid appears the cycle after the condition holds.
  - BURST: out_valid = !empty. On each pop (out_valid && out_ready), if the popped beat has out_last, return to IDLE; otherwise stay. out_threshold is ignored mid-packet. If the FIFO goes empty mid-packet (cut_mode only), out_valid drops and the FSM stays in BURST.
- Latency: a single-beat packet pushed in cycle N, with out_threshold = 1 and IDLE, gives the state update at N+1 and out_valid = 1 at N+2. Back-to-back packets have one idle cycle between an out_last pop and the next packet's first beat.
- Cut-through fallback:
  - If full && pkt_cnt == 0 (packet longer than DEPTH), set cut_mode and set err_oversize.
  - cut_mode is cleared on the pop of an out_last beat.
  - err_oversize clears only on rst.
- in_threshold: registered from the next-state free count (DEPTH - occupancy >= THRESH).
- Simultaneous push and pop when full: not possible, since in_ready = 0 while full. When empty, a push is not visible on out_* until the next cycle (no bypass).
- Reset (async assert, sync release by the integrator):
  - pointers = 0, pkt_cnt = 0, state = IDLE, cut_mode = 0, err_oversize = 0.
  - out_valid = 0, in_ready = 1 (evaluates as !full, so 1 immediately), in_threshold = 1.
  - Reset mid-packet discards all stored beats, including partial packets; no partial output follows.
- Storage contents need no reset. out_* data is don't-care while out_valid = 0.

Test Plan:
- Single-beat store-and-forward: DEPTH = 16, out_threshold = 1, out_ready = 1. Push 1 beat (last = 1, payload = 0x...A5, srcid = 3) at cycle 0 → out_valid = 1 at cycle 2 with identical fields; pkt_cnt returns to 0.
- Hold until last: push 4 beats (last only on beat 4) with a 2-cycle gap between beats 2 and 3 → out_valid stays 0 until 2 cycles after beat 4. All 4 beats then emerge on consecutive cycles, out_last only on the 4th.
- Threshold gating:
  - Hold out_threshold = 0 with one complete 3-beat packet stored → no out_valid.
  - Raise out_threshold → packet starts.
  - Drop out_threshold after beat 1 → beats 2 and 3 still delivered.
- Full/backpressure, in_threshold: out_ready = 0, push two 8-beat packets → in_ready = 0 after 16 pushes; in_threshold falls after the 9th push (free = 7 < 8). Release out_ready → 16 beats delivered in order.
- Oversize fallback: push 20 beats with no last and out_ready = 1 → at 16 stored, err_oversize = 1 and beats drain. Beat 20 with last ends the packet, cut_mode clears, and err_oversize stays 1 until rst.
- Reset mid-packet: assert rst after 3 of 5 beats are pushed → out_valid = 0, in_ready = 1, in_threshold = 1, err_oversize = 0. A subsequent 1-beat packet is delivered alone.

Source files
------------

// File: rtl/dti_gnpd_pkt_buf.sv
// dti_gnpd_pkt_buf: store-and-forward beat FIFO that releases a packet only once its last beat is stored,
// with a cut-through fallback for packets longer than the buffer.
module dti_gnpd_pkt_buf #(
    parameter int DEPTH     = 16,
    parameter int MAX_PKT   = 8,
    parameter int PAYLOAD_W = 90,
    parameter int ID_W      = 6,
    parameter int THRESH    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic [ID_W-1:0]      in_srcid,
    input  logic [ID_W-1:0]      in_tgtid,
    input  logic                 in_qos,
    input  logic                 in_last,
    output logic                 in_threshold,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [ID_W-1:0]      out_srcid,
    output logic [ID_W-1:0]      out_tgtid,
    output logic                 out_qos,
    output logic                 out_last,
    input  logic                 out_threshold,
    output logic                 err_oversize
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = PAYLOAD_W + 2 * ID_W + 2;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {IDLE, BURST} state_t;

    if (DEPTH < MAX_PKT || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || THRESH < 1 || THRESH > DEPTH) begin : g_bad_cfg
        $error("dti_gnpd_pkt_buf: illegal parameter combination");
    end

    logic [EW-1:0] mem [DEPTH];
    logic [AW:0]   wptr, rptr, wptr_n, rptr_n, occ_n;
    logic [CW-1:0] pkt_cnt;
    logic          full, empty, push, pop, cut_mode, overflow;
    state_t        state, state_n;

    assign full     = (wptr ^ rptr) == {1'b1, {AW{1'b0}}};
    assign empty    = wptr == rptr;
    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign pop      = out_valid && out_ready;
    assign overflow = full && pkt_cnt == '0;
    assign wptr_n   = wptr + (AW + 1)'(push);
    assign rptr_n   = rptr + (AW + 1)'(pop);
    assign occ_n    = wptr_n - rptr_n;
    assign {out_last, out_qos, out_tgtid, out_srcid, out_payload} = mem[rptr[AW-1:0]];

    always_ff @(posedge clk)
        if (push) mem[wptr[AW-1:0]] <= {in_last, in_qos, in_tgtid, in_srcid, in_payload};

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wptr         <= '0;
            rptr         <= '0;
            pkt_cnt      <= '0;
            cut_mode     <= 1'b0;
            err_oversize <= 1'b0;
            in_threshold <= 1'b1;
        end else begin
            wptr         <= wptr_n;
            rptr         <= rptr_n;
            pkt_cnt      <= pkt_cnt + CW'(push && in_last) - CW'(pop && out_last);
            cut_mode     <= overflow ? 1'b1 : (pop && out_last) ? 1'b0 : cut_mode;
            err_oversize <= err_oversize | overflow;
            in_threshold <= (DEPTH - int'(occ_n)) >= THRESH;
        end

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_n;

    // out_threshold is only consulted when a new packet is about to start
    always_comb
        state_n = (state == IDLE)
            ? ((!empty && (pkt_cnt != '0 || cut_mode) && out_threshold) ? BURST : IDLE)
            : ((pop && out_last) ? IDLE : BURST);

    always_comb out_valid = (state == BURST) && !empty;
endmodule
